// File: rtl/cache_ctrl_nway_pkg.sv
// Shared definitions for the N-way cache control FSM: state encoding,
// write-policy constants and width helpers for way/beat indices.
package cache_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_WHIT   = 3'd2;
    localparam logic [2:0] ST_WTHRU  = 3'd3;
    localparam logic [2:0] ST_EVICT  = 3'd4;
    localparam logic [2:0] ST_FILL   = 3'd5;
    localparam logic [2:0] ST_UPDATE = 3'd6;
    localparam logic [2:0] ST_ACK    = 3'd7;

    localparam int WB = 1;
    localparam int WT = 0;

    // Index widths never collapse to zero so single-way/single-beat builds still have a port.
    function automatic int calc_way_w(input int ways);
        return (ways <= 1) ? 1 : $clog2(ways);
    endfunction

    function automatic int calc_beat_w(input int line_words);
        return (line_words <= 1) ? 1 : $clog2(line_words);
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Replacement-way chooser: lowest-index invalid way, else the round-robin pointer.
module cache_victim_sel
    import cache_defs::*;
#(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  logic [WAYS-1:0]  valid_way,
    input  logic [WAY_W-1:0] rr,
    output logic [WAY_W-1:0] victim
);

    logic [WAYS-1:0] invalid;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_inv
            assign invalid[gi] = ~valid_way[gi];
        end
    endgenerate

    // Scan high-to-low so the lowest invalid index is the last one written.
    always_comb begin
        victim = rr;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (invalid[i]) victim = WAY_W'(i);
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative cache: lookup, write hit/through,
// dirty eviction, multi-beat fill and acknowledge.
module cache_ctrl_nway
    import cache_defs::*;
#(
    parameter int  WAYS       = 4,
    parameter int  LINE_WORDS = 4,
    parameter int  WRITE_BACK = WB,
    localparam int WAY_W      = calc_way_w(WAYS),
    localparam int BEAT_W     = calc_beat_w(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sys_rd,
    input  logic              sys_wr,
    input  logic [WAYS-1:0]   hit_way,
    input  logic [WAYS-1:0]   valid_way,
    input  logic [WAYS-1:0]   dirty_way,
    input  logic              ram_ack,
    output logic              ram_avalid,
    output logic              ram_wr,
    output logic              ram_evict,
    output logic [BEAT_W-1:0] beat,
    output logic [WAY_W-1:0]  way,
    output logic              wr_tag,
    output logic              wr,
    output logic              select_data,
    output logic              set_dirty,
    output logic              clr_dirty,
    output logic              sys_ack
);

    logic [2:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  rr_q, rr_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              wthru_first_q, wthru_first_d;
    logic [WAY_W-1:0]  victim, hit_idx, lookup_way;
    logic              any_hit, last_beat;

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_way (valid_way),
        .rr        (rr_q),
        .victim    (victim)
    );

    // Lowest set bit wins when the tag compare reports more than one hit.
    always_comb begin
        hit_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) hit_idx = WAY_W'(i);
        end
    end

    assign any_hit    = |hit_way;
    assign lookup_way = any_hit ? hit_idx : victim;
    assign last_beat  = (beat_q == BEAT_W'(LINE_WORDS - 1));

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        rr_d          = rr_q;
        way_d         = way_q;
        wthru_first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sys_rd ^ sys_wr) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                way_d = lookup_way;
                if (any_hit) begin
                    if (!sys_wr) begin
                        state_d = ST_ACK;
                    end else if (WRITE_BACK != 0) begin
                        state_d = ST_WHIT;
                    end else begin
                        state_d       = ST_WTHRU;
                        wthru_first_d = 1'b1;
                    end
                end else if ((WRITE_BACK != 0) && valid_way[victim] && dirty_way[victim]) begin
                    state_d = ST_EVICT;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WHIT:  state_d = ST_ACK;
            ST_WTHRU: begin
                if (ram_ack) state_d = ST_ACK;
            end
            ST_EVICT: begin
                if (ram_ack) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_FILL: begin
                if (ram_ack) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_UPDATE;
                        rr_d    = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + WAY_W'(1);
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_UPDATE: state_d = ST_LOOKUP;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            rr_q          <= '0;
            way_q         <= '0;
            wthru_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            rr_q          <= rr_d;
            way_q         <= way_d;
            wthru_first_q <= wthru_first_d;
        end
    end

    // Moore decode; only `way` in LOOKUP and `wr` in FILL follow inputs directly.
    always_comb begin
        ram_avalid  = 1'b0;
        ram_wr      = 1'b0;
        ram_evict   = 1'b0;
        beat        = beat_q;
        way         = way_q;
        wr_tag      = 1'b0;
        wr          = 1'b0;
        select_data = 1'b0;
        set_dirty   = 1'b0;
        clr_dirty   = 1'b0;
        sys_ack     = 1'b0;
        case (state_q)
            ST_IDLE:   way = '0;
            ST_LOOKUP: way = lookup_way;
            ST_WHIT: begin
                wr        = 1'b1;
                set_dirty = 1'b1;
            end
            ST_WTHRU: begin
                wr         = wthru_first_q;
                ram_avalid = 1'b1;
                ram_wr     = 1'b1;
            end
            ST_EVICT: begin
                ram_avalid = 1'b1;
                ram_wr     = 1'b1;
                ram_evict  = 1'b1;
            end
            ST_FILL: begin
                ram_avalid  = 1'b1;
                select_data = 1'b1;
                wr          = ram_ack;
            end
            ST_UPDATE: begin
                wr_tag      = 1'b1;
                clr_dirty   = 1'b1;
                select_data = 1'b1;
            end
            ST_ACK:    sys_ack = 1'b1;
            default:   way = '0;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: a write-back and a write-through instance,
// checked cycle by cycle against transaction-level expected sequences.
module tb_cache_ctrl_nway;

    typedef struct packed {
        logic       avalid;
        logic       ram_wr;
        logic       evict;
        logic [1:0] beat;
        logic [1:0] way;
        logic       wr_tag;
        logic       wr;
        logic       sel;
        logic       set_d;
        logic       clr_d;
        logic       ack;
    } outs_t;

    typedef struct packed {
        logic [3:0] hit;
        logic       ram_ack;
        logic       rd;
        logic       wr;
        outs_t      exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic       rd = 1'b0, wr = 1'b0;
    logic [3:0] hit_way = '0, valid_way = '0, dirty_way = '0;
    logic       ram_ack = 1'b0;

    logic       rd_b, wr_b, rd_t, wr_t;
    logic       ram_avalid_b, ram_wr_b, ram_evict_b, wr_tag_b, wr_b_o, select_data_b, set_dirty_b, clr_dirty_b, sys_ack_b;
    logic [1:0] beat_b, way_b;
    logic       ram_avalid_t, ram_wr_t, ram_evict_t, wr_tag_t, wr_t_o, select_data_t, set_dirty_t, clr_dirty_t, sys_ack_t;
    logic [1:0] beat_t, way_t;
    outs_t      act_b, act_t, act;

    int   errors = 0;
    int   checks = 0;
    int   rr_wb = 0;
    int   rr_wt = 0;
    cyc_t seq[$];

    always #5 clk = ~clk;

    assign rd_b = sel ? 1'b0 : rd;
    assign wr_b = sel ? 1'b0 : wr;
    assign rd_t = sel ? rd : 1'b0;
    assign wr_t = sel ? wr : 1'b0;

    cache_ctrl_nway #(.WAYS(4), .LINE_WORDS(4), .WRITE_BACK(1)) dut_wb (
        .clk(clk), .reset(reset), .sys_rd(rd_b), .sys_wr(wr_b),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way), .ram_ack(ram_ack),
        .ram_avalid(ram_avalid_b), .ram_wr(ram_wr_b), .ram_evict(ram_evict_b), .beat(beat_b),
        .way(way_b), .wr_tag(wr_tag_b), .wr(wr_b_o), .select_data(select_data_b),
        .set_dirty(set_dirty_b), .clr_dirty(clr_dirty_b), .sys_ack(sys_ack_b)
    );

    cache_ctrl_nway #(.WAYS(4), .LINE_WORDS(4), .WRITE_BACK(0)) dut_wt (
        .clk(clk), .reset(reset), .sys_rd(rd_t), .sys_wr(wr_t),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way), .ram_ack(ram_ack),
        .ram_avalid(ram_avalid_t), .ram_wr(ram_wr_t), .ram_evict(ram_evict_t), .beat(beat_t),
        .way(way_t), .wr_tag(wr_tag_t), .wr(wr_t_o), .select_data(select_data_t),
        .set_dirty(set_dirty_t), .clr_dirty(clr_dirty_t), .sys_ack(sys_ack_t)
    );

    assign act_b = {ram_avalid_b, ram_wr_b, ram_evict_b, beat_b, way_b, wr_tag_b, wr_b_o,
                    select_data_b, set_dirty_b, clr_dirty_b, sys_ack_b};
    assign act_t = {ram_avalid_t, ram_wr_t, ram_evict_t, beat_t, way_t, wr_tag_t, wr_t_o,
                    select_data_t, set_dirty_t, clr_dirty_t, sys_ack_t};
    assign act   = sel ? act_t : act_b;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, got, want);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int victim_of(input logic [3:0] valid, input int rr);
        for (int i = 0; i < 4; i++) if (!valid[i]) return i;
        return rr;
    endfunction

    task automatic push(input logic [3:0] h, input logic ack, input logic r, input logic w, input outs_t o);
        cyc_t c;
        c.hit = h; c.ram_ack = ack; c.rd = r; c.wr = w; c.exp = o;
        seq.push_back(c);
    endtask

    // One line burst: every beat waits `lat` cycles then sees its ack.
    task automatic burst(input bit ev, input int w, input int lat, input logic [3:0] h, input logic r, input logic wq);
        outs_t o;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k <= lat; k++) begin
                o = '0;
                o.avalid = 1'b1; o.ram_wr = ev; o.evict = ev; o.sel = !ev;
                o.beat = 2'(b); o.way = 2'(w);
                o.wr = !ev && (k == lat);
                push(h, k == lat, r, wq, o);
            end
        end
    endtask

    // Expected cycle-by-cycle trace of one request, from request-in-IDLE to the idle after ack.
    task automatic build(input bit wb, input bit is_wr, input logic [3:0] hit,
                         input logic [3:0] valid, input logic [3:0] dirty, input int lat);
        outs_t      o;
        int         w;
        int         rr;
        logic       r;
        logic [3:0] h;
        r  = !is_wr;
        h  = hit;
        rr = wb ? rr_wb : rr_wt;
        seq.delete();
        push(h, 1'b0, r, is_wr, '0);
        if (h == 4'b0000) begin
            w = victim_of(valid, rr);
            o = '0; o.way = 2'(w);
            push(h, 1'b0, r, is_wr, o);
            if (wb && valid[w] && dirty[w]) burst(1'b1, w, lat, h, r, is_wr);
            burst(1'b0, w, lat, h, r, is_wr);
            o = '0; o.wr_tag = 1'b1; o.clr_d = 1'b1; o.sel = 1'b1; o.way = 2'(w);
            push(h, 1'b0, r, is_wr, o);
            rr = (rr + 1) % 4;
            h  = 4'b0001 << w;
        end
        w = lowest(h);
        o = '0; o.way = 2'(w);
        push(h, 1'b0, r, is_wr, o);
        if (is_wr && wb) begin
            o = '0; o.wr = 1'b1; o.set_d = 1'b1; o.way = 2'(w);
            push(h, 1'b0, r, is_wr, o);
        end else if (is_wr) begin
            for (int k = 0; k <= lat; k++) begin
                o = '0; o.avalid = 1'b1; o.ram_wr = 1'b1; o.way = 2'(w); o.wr = (k == 0);
                push(h, k == lat, r, is_wr, o);
            end
        end
        o = '0; o.ack = 1'b1; o.way = 2'(w);
        push(h, 1'b0, r, is_wr, o);
        push(h, 1'b0, 1'b0, 1'b0, '0);
        if (wb) rr_wb = rr; else rr_wt = rr;
    endtask

    task automatic run_seq(input string name, input bit which, input int cut, output int ack_at);
        int last;
        ack_at = -1;
        last   = (cut >= 0) ? cut : seq.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(posedge clk); #1;
            sel = which; hit_way = seq[i].hit; ram_ack = seq[i].ram_ack;
            rd = seq[i].rd; wr = seq[i].wr;
            if (i == cut) reset = 1'b1;
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, i), 32'(act), 32'(seq[i].exp));
            if (act.ack && ack_at < 0) ack_at = i;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; ram_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rr_wb = 0; rr_wt = 0;
    endtask

    initial begin
        int ack_at;
        int cut;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs_wb", 32'(act_b), 32'd0);
        check("reset_outs_wt", 32'(act_t), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        valid_way = 4'b1111; dirty_way = 4'b0000;
        build(1, 0, 4'b0100, valid_way, dirty_way, 0);
        run_seq("rd_hit", 0, -1, ack_at);
        check("rd_hit_ack_cycle", ack_at, 2);

        build(1, 1, 4'b0001, valid_way, dirty_way, 0);
        run_seq("wr_hit_wb", 0, -1, ack_at);
        check("wr_hit_wb_ack_cycle", ack_at, 3);

        valid_way = 4'b1011; dirty_way = 4'b1111;
        build(1, 0, 4'b0000, valid_way, dirty_way, 0);
        check("model_rr_after_clean_miss", rr_wb, 1);
        run_seq("clean_miss", 0, -1, ack_at);
        check("clean_miss_ack_cycle", ack_at, 8);

        do_reset();
        valid_way = 4'b1111; dirty_way = 4'b0001;
        build(1, 0, 4'b0000, valid_way, dirty_way, 0);
        check("model_rr_after_dirty_miss", rr_wb, 1);
        run_seq("dirty_miss", 0, -1, ack_at);
        check("dirty_miss_ack_cycle", ack_at, 12);

        dirty_way = 4'b0010;
        build(1, 1, 4'b0000, valid_way, dirty_way, 1);
        run_seq("dirty_wr_miss_lat1", 0, -1, ack_at);
        check("dirty_wr_miss_ack_cycle", ack_at, 21);

        build(1, 0, 4'b0110, valid_way, dirty_way, 0);
        run_seq("multi_hit", 0, -1, ack_at);
        check("multi_hit_ack_cycle", ack_at, 2);

        build(0, 1, 4'b0010, valid_way, dirty_way, 3);
        run_seq("wthru_hit_lat3", 1, -1, ack_at);
        check("wthru_hit_ack_cycle", ack_at, 6);

        dirty_way = 4'b1111;
        build(0, 1, 4'b0000, valid_way, dirty_way, 0);
        run_seq("wthru_miss", 1, -1, ack_at);
        check("wthru_miss_ack_cycle", ack_at, 9);
        check("model_rr_wt", rr_wt, 1);

        valid_way = 4'b0111; dirty_way = 4'b0000;
        build(1, 0, 4'b0000, valid_way, dirty_way, 0);
        cut = 0;
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i].exp.avalid && seq[i].exp.sel && seq[i].exp.beat == 2'd2) begin
                cut = i;
                break;
            end
        end
        run_seq("reset_mid_fill", 0, cut, ack_at);
        @(posedge clk); #1;
        reset = 1'b0; rd = 1'b1; wr = 1'b1; ram_ack = 1'b0; hit_way = '0;
        @(negedge clk);
        check("after_reset_idle", 32'(act_b), 32'd0);
        check("after_reset_beat", 32'(beat_b), 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("illegal_rd_wr_stays_idle", 32'(act_b), 32'd0);
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised successor to the single-way cache control FSM. It sequences lookup, write hit, dirty-line eviction, multi-beat line fill and acknowledge for an N-way set-associative cache with configurable line length and write policy. It sits between the system request port and the RAM port, driving tag/data array write enables and mux selects. Tag compare and the arrays stay outside the block.

## Interface
Parameters:
- WAYS, 4: associativity; power of two, 1..16.
- LINE_WORDS, 4: RAM beats per line; power of two, 1..64.
- WRITE_BACK, 1: 1 = write-back with dirty eviction; 0 = write-through, no dirty bits used.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- sys_rd, sys_wr  in  1 each  request; held until sys_ack; both high = illegal, ignored.
- hit_way  in  WAYS  one-hot tag-match vector for the indexed set.
- valid_way, dirty_way  in  WAYS each  valid/dirty bits of the indexed set.
- ram_ack  in  1  per-beat RAM completion.
- ram_avalid  out  1  RAM beat request.
- ram_wr  out  1  1 = eviction or write-through write; 0 = fill read.
- ram_evict  out  1  RAM address uses the victim tag (1) or the request tag (0).
- beat  out  log2(LINE_WORDS) (min 1)  current word offset of a burst.
- way  out  log2(WAYS) (min 1)  way selected for array access.
- wr_tag, wr  out  1 each  tag-array and data-array write enables.
- select_data  out  1  data-in mux: 0 = system data, 1 = RAM data.
- set_dirty, clr_dirty  out  1 each  dirty-bit update for `way`.
- sys_ack  out  1  one-cycle request completion.

## Operation
- States: IDLE, LOOKUP, WHIT, WTHRU, EVICT, FILL, UPDATE, ACK.
- IDLE: exactly one of sys_rd or sys_wr is high -> LOOKUP. Otherwise stay.
- LOOKUP:
  - Any hit: `way` = index of the hit. Multi-hot input: lowest index wins.
  - Read hit -> ACK.
  - Write hit -> WHIT (WRITE_BACK=1) or WTHRU (WRITE_BACK=0).
  - Miss: `way` = victim, latched. Victim valid and dirty with WRITE_BACK=1 -> EVICT. Otherwise -> FILL.
- Victim selection: lowest-index invalid way first. If all ways are valid, use round-robin pointer rr.
  - rr resets to 0.
  - rr advances by 1 on entry to UPDATE and wraps from WAYS-1 to 0.
- WHIT: wr=1, set_dirty=1 for one cycle -> ACK.
- WTHRU: wr=1 in the first cycle. ram_avalid=1, ram_wr=1 held until ram_ack -> ACK.
- EVICT: ram_avalid=1, ram_wr=1, ram_evict=1, select_data=0.
  - beat increments on each ram_ack.
  - ram_ack with beat==LINE_WORDS-1 -> beat=0 -> FILL.
- FILL: ram_avalid=1, ram_wr=0, select_data=1.
  - wr=1 only in the cycle where ram_ack=1 (RAM data is valid that cycle).
  - beat increments per ack.
  - Last ack -> beat=0 -> UPDATE.
- UPDATE: wr_tag=1, clr_dirty=1, select_data=1 for one cycle -> LOOKUP. The re-lookup must hit.
- ACK: sys_ack=1 for one cycle -> IDLE.
- Request inputs are not re-sampled between LOOKUP and ACK. sys_wr in LOOKUP decides read vs write.

## Timing
- Reset: state=IDLE, beat=0, rr=0. All outputs 0, including way.
- Outputs are decoded from state (Moore). Exceptions, which are combinational on the input: wr in FILL (ram_ack) and way in LOOKUP (hit_way/victim).
- Read hit: request high at edge 0 -> LOOKUP at edge 1 -> sys_ack high during cycle 2.
- Write hit, WRITE_BACK=1: sys_ack in cycle 3.
- Clean miss, zero-wait RAM: 1 + LINE_WORDS + 1 + 1 + 1 cycles to sys_ack.
- Dirty miss: add LINE_WORDS EVICT cycles.
- ram_avalid stays high across beats within a burst. It never drops until the last ack.
- ram_ack outside EVICT, FILL and WTHRU is ignored.
- Reset mid-burst: returns to IDLE on the same edge. The line is left without a tag update; the arrays hold stale but untagged data.
- WAYS=1: victim is always 0 and rr stays 0. LINE_WORDS=1: each burst is one beat.

## Structure
- Shared package cache_defs:
  - state encoding constants.
  - clog2 width helpers: WAY_W, BEAT_W.
  - policy constants WB and WT.
- Sub-module cache_victim_sel:
  - inputs valid_way and rr.
  - output victim index.
  - purely combinational priority encoder plus pointer fallback.
- rr register and beat counter live in the top level.

## Test plan
- WAYS=4, LINE_WORDS=4, read with hit_way=4'b0100 -> way=2, sys_ack in cycle 2, no RAM activity.
- Write hit with hit_way=4'b0001, WRITE_BACK=1 -> wr and set_dirty high for 1 cycle with way=0; sys_ack in cycle 3.
- Read miss, valid_way=4'b1011 -> victim way 2, 4 FILL beats with beat 0..3, wr_tag in UPDATE, rr stays then advances to 1; sys_ack after re-lookup hit.
- Read miss, valid_way=4'b1111, dirty_way=4'b0001, rr=0 -> 4 EVICT beats with ram_wr=1 and ram_evict=1, then 4 FILL beats; clr_dirty asserted; rr becomes 1.
- WRITE_BACK=0 write hit with ram_ack delayed 3 cycles -> ram_avalid held 4 cycles; set_dirty never asserted; sys_ack the cycle after ram_ack.
- Reset pulse during FILL beat 2 -> next cycle IDLE, all outputs 0, beat=0; sys_rd=sys_wr=1 in IDLE -> stays IDLE.
